// File: rtl/fpadd_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared fpadd.
// The arbiter uses the slave modport; requesters and fpadd use master.
interface fpadd_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       fp_start;
  logic [7:0] fp_a;
  logic [7:0] fp_b;
  logic       fp_done;
  logic [7:0] fp_s;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] result;
  logic       err;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, fp_done, fp_s,
    output fp_start, fp_a, fp_b, gnt0, gnt1, done0, done1, result, err
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, fp_done, fp_s,
    input  fp_start, fp_a, fp_b, gnt0, gnt1, done0, done1, result, err
  );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one fpadd unit between two requesters.
// Optional WAIT timeout abort enabled by defining FPARB_TIMEOUT_EN.
module fpadd_arbiter #(
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            clr,
  fpadd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
    $error("TIMEOUT must fit the 5-bit wait counter");
  end

  state_t     state_q, state_d;
  logic       own_q, own_d;
  logic       last_q, last_d;
  logic [7:0] fpa_q, fpa_d;
  logic [7:0] fpb_q, fpb_d;
  logic [7:0] res_q, res_d;

`ifdef FPARB_TIMEOUT_EN
  logic [4:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    fpa_d   = fpa_q;
    fpb_d   = fpb_q;
    res_d   = res_q;
`ifdef FPARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // a lone request wins; a tie goes to whoever was not served last
          own_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          fpa_d   = own_d ? bus.a1 : bus.a0;
          fpb_d   = own_d ? bus.b1 : bus.b0;
          state_d = ISSUE;
`ifdef FPARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FPARB_TIMEOUT_EN
        cnt_d   = 5'd0;
`endif
      end
      WAIT: begin
        if (bus.fp_done) begin
          res_d   = bus.fp_s;
          state_d = RESP;
`ifdef FPARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q + 5'd1 == 5'(TIMEOUT)) begin
          res_d   = 8'h00;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 5'd1;
`endif
        end
      end
      RESP: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      fpa_q   <= 8'h00;
      fpb_q   <= 8'h00;
      res_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      fpa_q   <= fpa_d;
      fpb_q   <= fpb_d;
      res_q   <= res_d;
    end
  end

`ifdef FPARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= 5'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = (state_q == RESP) && err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.fp_start = (state_q == ISSUE);
  assign bus.fp_a     = fpa_q;
  assign bus.fp_b     = fpb_q;
  assign bus.gnt0     = (state_q != IDLE) && !own_q;
  assign bus.gnt1     = (state_q != IDLE) &&  own_q;
  assign bus.done0    = (state_q == RESP) && !own_q;
  assign bus.done1    = (state_q == RESP) &&  own_q;
  assign bus.result   = res_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter: a driver pushes expectations from a
// round-robin model, an fpadd model answers, and a monitor pops and compares.
module tb_fpadd_arbiter;

  typedef struct {
    bit         own;
    logic [7:0] a;
    logic [7:0] b;
  } iss_t;

  typedef struct {
    bit         own;
    logic [7:0] res;
    bit         err;
    int         delta;
  } rsp_t;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   last_m = 1'b1;

  iss_t       iss_q[$];
  rsp_t       rsp_q[$];
  int         lat_q[$];
  logic [7:0] s_q[$];

  fpadd_arbiter_if bus();

  fpadd_arbiter #(.TIMEOUT(31)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks every issue and completion against the queues.
  initial begin : mon
    bit         cur_own;
    logic [7:0] cur_a;
    logic [7:0] cur_b;
    int         st_cyc;
    bit         prev_start;
    iss_t       ie;
    rsp_t       re;
    cur_own    = 1'b0;
    cur_a      = 8'h00;
    cur_b      = 8'h00;
    st_cyc     = 0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_start = 1'b0;
      end else begin
        if (bus.fp_start) begin
          chk("start_one_cycle", 32'(prev_start), 0);
          if (iss_q.size() == 0) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            ie      = iss_q.pop_front();
            cur_own = ie.own;
            cur_a   = ie.a;
            cur_b   = ie.b;
            st_cyc  = cyc;
          end
        end
        prev_start = bus.fp_start;
        if (bus.gnt0 || bus.gnt1) begin
          chk("gnt0", 32'(bus.gnt0), 32'(!cur_own));
          chk("gnt1", 32'(bus.gnt1), 32'(cur_own));
          chk("fp_a", 32'(bus.fp_a), 32'(cur_a));
          chk("fp_b", 32'(bus.fp_b), 32'(cur_b));
        end else begin
          chk("done_without_gnt", 32'(bus.done0 | bus.done1), 0);
        end
        if (bus.done0 || bus.done1) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            re = rsp_q.pop_front();
            chk("done0", 32'(bus.done0), 32'(!re.own));
            chk("done1", 32'(bus.done1), 32'(re.own));
            chk("result", 32'(bus.result), 32'(re.res));
            chk("err", 32'(bus.err), 32'(re.err));
            chk("latency", 32'(cyc - st_cyc), 32'(re.delta));
          end
        end else begin
          chk("err_without_done", 32'(bus.err), 0);
        end
      end
    end
  end

  // fpadd model: answers each start after a queued latency with a queued sum,
  // sometimes holding fp_done one extra cycle with a different fp_s.
  initial begin : fpm
    int         l;
    logic [7:0] s;
    bus.fp_done = 1'b0;
    bus.fp_s    = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.fp_start && !clr) begin
        l = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
        s = (s_q.size() != 0) ? s_q.pop_front() : 8'h00;
        repeat (l) @(negedge clk);
        bus.fp_done = 1'b1;
        bus.fp_s    = s;
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
          bus.fp_s = 8'($urandom);
          @(negedge clk);
        end
        bus.fp_done = 1'b0;
        bus.fp_s    = 8'($urandom);
      end
    end
  end

  // Pushes the expected outcome of the next arbitration and follows it.
  task automatic serve(input int lat, input logic [7:0] s,
                       input bit drop_early, input bit scramble,
                       output bit own);
    iss_t i;
    rsp_t r;
    int   n;
    own    = (bus.req0 && bus.req1) ? !last_m : bus.req1;
    last_m = own;
    i.own  = own;
    i.a    = own ? bus.a1 : bus.a0;
    i.b    = own ? bus.b1 : bus.b0;
    r.own   = own;
    r.res   = s;
    r.err   = 1'b0;
    r.delta = lat + 1;
`ifdef FPARB_TIMEOUT_EN
    if (lat > 31) begin
      r.res   = 8'h00;
      r.err   = 1'b1;
      r.delta = 32;
    end
`endif
    iss_q.push_back(i);
    rsp_q.push_back(r);
    lat_q.push_back(lat);
    s_q.push_back(s);
    n = 0;
    while (!bus.fp_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_start", 32'(n < 100), 1);
    @(negedge clk);
    if (scramble) begin
      if (own) begin
        bus.a1 = ~bus.a1;
        bus.b1 = ~bus.b1;
      end else begin
        bus.a0 = ~bus.a0;
        bus.b0 = ~bus.b0;
      end
    end
    if (drop_early) begin
      if (own) bus.req1 = 1'b0;
      else     bus.req0 = 1'b0;
    end
    n = 0;
    while (!(bus.done0 || bus.done1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 32'(n < 200), 1);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    clr    = 1'b0;
    last_m = 1'b1;
    iss_q.delete();
    rsp_q.delete();
  endtask

  initial begin : drv
    bit o;
    int n;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = 8'h00;
    bus.b0   = 8'h00;
    bus.a1   = 8'h00;
    bus.b1   = 8'h00;
    clr      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fp_start", 32'(bus.fp_start), 0);
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_done0", 32'(bus.done0), 0);
    chk("rst_done1", 32'(bus.done1), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_fp_a", 32'(bus.fp_a), 0);
    chk("rst_fp_b", 32'(bus.fp_b), 0);
    chk("rst_result", 32'(bus.result), 0);
    clr = 1'b0;
    @(negedge clk);

    // single requester 0
    bus.a0   = 8'h3C;
    bus.b0   = 8'h42;
    bus.req0 = 1'b1;
    serve(3, 8'h47, 1'b0, 1'b0, o);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("result_hold", 32'(bus.result), 32'h47);

    // tie held for three operations from reset: 0,1,0
    do_reset();
    bus.a0   = 8'h01;
    bus.b0   = 8'h02;
    bus.a1   = 8'h81;
    bus.b1   = 8'h82;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int k = 0; k < 3; k++) serve(2, 8'(8'h10 + k), 1'b0, 1'b0, o);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // operands change and req drops after the grant
    bus.a1   = 8'h11;
    bus.b1   = 8'h22;
    bus.req1 = 1'b1;
    serve(2, 8'h33, 1'b1, 1'b1, o);
    repeat (2) @(negedge clk);

    // reset during WAIT, late fp_done ignored
    bus.req1 = 1'b1;
    iss_q.push_back('{own: 1'b1, a: bus.a1, b: bus.b1});
    lat_q.push_back(5);
    s_q.push_back(8'h99);
    n = 0;
    while (!bus.fp_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_start_clr", 32'(n < 100), 1);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_gnt1", 32'(bus.gnt1), 0);
    chk("clr_fp_start", 32'(bus.fp_start), 0);
    chk("clr_fp_a", 32'(bus.fp_a), 0);
    chk("clr_result", 32'(bus.result), 0);
    bus.req1 = 1'b0;
    @(negedge clk);
    clr    = 1'b0;
    last_m = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_clr_idle", 32'({bus.gnt0, bus.gnt1, bus.result}), 0);
    end
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    serve(2, 8'h5A, 1'b0, 1'b0, o);
    bus.req0 = 1'b0;
    serve(1, 8'hA5, 1'b0, 1'b0, o);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // fpadd never answers in time, then answers exactly at the limit
    bus.req0 = 1'b1;
    serve(40, 8'h77, 1'b0, 1'b0, o);
    bus.req0 = 1'b0;
    repeat (15) @(negedge clk);
    bus.req1 = 1'b1;
    serve(31, 8'h66, 1'b0, 1'b0, o);
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel      = int'($urandom_range(1, 3));
      bus.a0   = 8'($urandom);
      bus.b0   = 8'($urandom);
      bus.a1   = 8'($urandom);
      bus.b1   = 8'($urandom);
      bus.req0 = sel[0];
      bus.req1 = sel[1];
      serve(int'($urandom_range(1, 6)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
      if (o) bus.req1 = 1'b0;
      else   bus.req0 = 1'b0;
      if (sel == 3) begin
        serve(int'($urandom_range(1, 6)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("issue_queue_drained", 32'(iss_q.size()), 0);
    chk("resp_queue_drained", 32'(rsp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpadd_arbiter.md
FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 31, max WAIT cycles before abort (used only with FPARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr  input  1  reset; asynchronous, active-high.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1; held high until matching done pulse.
REQ-005 a0, b0, a1, b1  input  8 each  operands from each requester; valid while its req is high.
REQ-006 fp_start  output  1  one-cycle start pulse to the shared fpadd unit.
REQ-007 fp_a, fp_b  output  8 each  latched operands to fpadd; stable from ISSUE through WAIT.
REQ-008 fp_done  input  1  fpadd completion strobe; fp_s is valid in the same cycle.
REQ-009 fp_s  input  8  fpadd sum.
REQ-010 gnt0, gnt1  output  1 each  owner indication, high from ISSUE through RESP for the granted requester.
REQ-011 done0, done1  output  1 each  one-cycle completion pulse to the owner.
REQ-012 result  output  8  registered sum; holds its value until the next RESP.
REQ-013 err  output  1  timeout flag, pulsed with done (FPARB_TIMEOUT_EN only).

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; all outputs decode from registered state, owner and result.
REQ-015 IDLE: if neither req is high, SHALL stay in IDLE; otherwise SHALL select an owner, latch the owner's a/b into fp_a/fp_b, and go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: when both reqs are high, the requester not served last wins; a single request wins regardless of the pointer.
REQ-017 ISSUE: fp_start SHALL be high for exactly this one cycle, then go to WAIT unconditionally.
REQ-018 WAIT: on fp_done=1, SHALL capture fp_s into result and go to RESP; otherwise stay in WAIT.
REQ-019 RESP: done of the owner SHALL be high for this one cycle; the last-served pointer SHALL update to the owner; then go to IDLE.
REQ-020 Latency: req sampled in IDLE at edge k SHALL produce fp_start during cycle k+1; fp_done at edge m SHALL produce done during cycle m+1.
REQ-021 fp_done outside WAIT SHALL be ignored.
REQ-022 Deasserting req after the grant SHALL NOT abort the operation; the operation completes and done still pulses.
REQ-023 Changes on a/b after the grant SHALL NOT affect fp_a/fp_b.
REQ-024 The minimum back-to-back spacing SHALL be 4 cycles (IDLE->ISSUE->WAIT->RESP) plus fpadd latency; no grant SHALL be issued outside IDLE.
REQ-025 The non-owner gnt and done SHALL remain 0 throughout an operation.

Reset
REQ-026 On clr=1, the block SHALL asynchronously enter IDLE with fp_start, gnt0, gnt1, done0, done1 and err at 0, fp_a/fp_b/result at 8'h00, and the timeout counter at 0.
REQ-027 After reset, the last-served pointer SHALL be set to requester 1, so requester 0 wins the first tie.
REQ-028 clr asserted mid-operation SHALL abandon the operation with no done pulse; a later fp_done SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-029 With FPARB_TIMEOUT_EN defined, a 5-bit counter SHALL clear on entering WAIT and increment each WAIT cycle without fp_done.
REQ-030 With FPARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT the FSM SHALL go to RESP with result=8'h00 and err=1 alongside done.
REQ-031 With FPARB_TIMEOUT_EN defined, fp_done in the same cycle as the timeout SHALL win: the normal result is captured and err=0.
REQ-032 Without FPARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, err SHALL be tied to 0, and no counter SHALL be present.

Verification
REQ-033 Bench SHALL cover: req0=1, a0=8'h3C, b0=8'h42, model fp_done 3 cycles after fp_start with fp_s=8'h47 -> fp_a=8'h3C, fp_b=8'h42, fp_start 1 cycle, done0 1 cycle, result=8'h47, gnt1/done1 stay 0.
REQ-034 Bench SHALL cover: req0 and req1 high together from reset, held for 3 operations -> owner order 0,1,0.
REQ-035 Bench SHALL cover: a1 changed from 8'h11 to 8'hEE one cycle after gnt1 rises, with req1 dropped -> fp_a stays 8'h11 and done1 still pulses.
REQ-036 Bench SHALL cover: clr pulsed during WAIT, then fp_done asserted -> no done pulse, all outputs 0, and the next tie is granted to requester 0.
REQ-037 Bench SHALL cover, with FPARB_TIMEOUT_EN and TIMEOUT=31: fp_done never asserted -> done pulses with err=1 and result=8'h00 on the 32nd cycle after fp_start.
REQ-038 Bench SHALL cover, with FPARB_TIMEOUT_EN: fp_done coincident with the timeout -> err=0 and result=fp_s.
